seq_mult_bcd_conv: RTL and testbench
====================================

Name: seq_mult_bcd_conv

Overview:
Sequential N-bit multiplier with a built-in Double Dabble binary-to-BCD converter, wrapped in valid/ready handshakes. The digit count is parametrised, signed and unsigned modes are supported, and a decimal-overflow flag is provided. It is the next generation of the team's multiplier/BCD block, intended to feed display and readout paths. One operation is in flight at a time, with a fixed latency of 3N cycles.

Parameters:
N, 8, operand width in bits (N >= 2).
DIGITS, 5, number of BCD output digits (4 bits each).
SIGNED, 0, 0 = unsigned operands; 1 = two's-complement operands, sign-magnitude BCD output.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
in_valid  in  1  operands A and B are valid.
in_ready  out  1  block accepts operands; high only in IDLE.
A  in  N  operand A.
B  in  N  operand B.
out_valid  out  1  result valid; held until accepted.
out_ready  in  1  consumer accepts the result.
product  out  2N  binary product (two's complement when SIGNED=1).
bcd  out  4*DIGITS  BCD magnitude; digit 0 is in bits [3:0].
sign  out  1  1 = negative result (SIGNED=1 only, else 0).
bcd_ovf  out  1  magnitude exceeds 10^DIGITS-1.

Behaviour:
- Reset (async, any state): state=IDLE. All outputs are 0 except in_ready=1. Internal registers are cleared. An in-flight operation is discarded and produces no output.
- FSM states: IDLE, MULT, CONV, DONE.
- IDLE: in_ready=1. On an edge with in_valid&&in_ready (edge E0):
  - capture the operand magnitudes (|A|, |B| when SIGNED=1, else A, B);
  - capture sign = A[N-1]^B[N-1] (SIGNED=1, else 0);
  - clear the accumulator, BCD register and overflow flag;
  - go to MULT.
- Operands are sampled only at E0; later changes to A/B are ignored.
- MULT: shift-add multiply, one multiplier bit per cycle, N cycles (edges E1..EN).
  - Product magnitude is 2N bits wide and can never overflow (|-2^(N-1)|^2 < 2^(2N)).
  - At EN go to CONV; the magnitude is loaded into the conversion shift register.
- CONV: Double Dabble, 2N cycles (edges EN+1..E3N). Each cycle, in this order:
  - every digit >= 5 gets +3;
  - the corrected digit chain shifts left one bit, taking the MSB of the shift register into digit 0;
  - the shift register shifts left, with 0 into its LSB.
  - The add-3 correction must be applied before the shift within the same cycle (combinational correct-then-register).
  - A 1 shifted out of the top digit sets the sticky flag bcd_ovf. The retained digits then hold magnitude mod 10^DIGITS.
- At E3N go to DONE. out_valid=1 is visible after E3N, so latency from accept to out_valid is exactly 3N cycles.
- DONE: product, bcd, sign and bcd_ovf are stable and out_valid=1.
  - On an edge with out_ready=1: out_valid goes to 0, state goes to IDLE, and in_ready=1 from the next cycle.
  - out_ready low holds every output indefinitely.
- product output:
  - SIGNED=0: the magnitude.
  - SIGNED=1: the two's complement of the magnitude if sign=1.
- Zero result: sign is forced to 0 (no negative zero), bcd is all zeros.
- Data outputs keep their last value after handshake completion until the next result updates them at E3N.
- in_ready is 0 in MULT, CONV and DONE. in_valid is ignored there, so there is no overlap or queueing.
- out_ready while out_valid=0 has no effect.

Decomposition:
- Package mult_bcd_pkg holds:
  - the state enum (IDLE, MULT, CONV, DONE);
  - ADD_THREE=4'd3 and BCD_CORRECT_THRESH=4'd5;
  - function min_digits(N), returning ceil(2N*log10(2)), for elaboration checks and bench use.
- One sub-module, bcd_double_dabble:
  - the sequential converter (load, 2N-cycle shift/correct, done pulse, overflow flag);
  - parametrised by WIDTH=2N and DIGITS.
- The top module keeps the handshake FSM, the shift-add multiplier and sign handling.

Test Plan:
- SIGNED=0, N=8, DIGITS=5: A=255, B=255 → product=16'hFE01, bcd=20'h65025, sign=0, bcd_ovf=0; out_valid exactly 24 cycles after the accept edge.
- SIGNED=1: A=-12 (8'hF4), B=11 → product=16'hFF7C, sign=1, bcd=20'h00132. Also A=-128, B=-128 → product=16'h4000, sign=0, bcd=20'h16384.
- SIGNED=1: A=-5, B=0 → product=0, sign=0, bcd=0. SIGNED=0: A=0, B=0 → all zero, same 24-cycle latency.
- DIGITS=4: A=200, B=100 → product=16'h4E20, bcd=16'h0000, bcd_ovf=1. A=99, B=101 (9999) → bcd=16'h9999, bcd_ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → out_valid, product and bcd stable; in_ready=0; in_valid pulses ignored. Raising out_ready → out_valid=0 next cycle, in_ready=1.
- Reset asserted mid-CONV (e.g. cycle 12 after accept) → all outputs 0 and in_ready=1 immediately, no out_valid. The next operation, 7*6, gives bcd=20'h00042.

Source files
------------

// File: rtl/seq_mult_bcd_conv_pkg.sv
// mult_bcd_pkg: shared types and constants for the sequential multiplier with
// built-in Double Dabble binary-to-BCD conversion.
//   state_t            : handshake FSM states (IDLE, MULT, CONV, DONE)
//   ADD_THREE          : correction added to a BCD digit before shifting
//   BCD_CORRECT_THRESH : digit value at or above which the correction applies
//   min_digits(n)      : ceil(2n*log10(2)), the number of decimal digits needed
//                        to hold any 2n-bit magnitude without overflow
package mult_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    CONV = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] ADD_THREE          = 4'd3;
  localparam logic [3:0] BCD_CORRECT_THRESH = 4'd5;

  // log10(2) ~= 0.30103, scaled to integers and rounded up.
  function automatic int min_digits(input int n);
    return (2 * n * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/seq_mult_bcd_conv_if.sv
// seq_mult_bcd_conv_if: operand/result handshake bundle of seq_mult_bcd_conv.
//   in_valid/in_ready   : operand handshake, A and B qualified by in_valid
//   out_valid/out_ready : result handshake
//   product             : 2N-bit binary product
//   bcd                 : DIGITS BCD digits of the magnitude, digit 0 in [3:0]
//   sign                : negative result (signed mode only)
//   bcd_ovf             : magnitude did not fit in DIGITS digits
// master = operand producer / result consumer, slave = the multiplier.
interface seq_mult_bcd_conv_if #(
  parameter int N      = 8,
  parameter int DIGITS = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [N-1:0]          A;
  logic [N-1:0]          B;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*N-1:0]        product;
  logic [4*DIGITS-1:0]   bcd;
  logic                  sign;
  logic                  bcd_ovf;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, product, bcd, sign, bcd_ovf
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, product, bcd, sign, bcd_ovf
  );
endinterface

// File: rtl/seq_mult_bcd_conv_bcd_double_dabble.sv
// bcd_double_dabble: sequential binary-to-BCD converter (shift-and-add-3).
//   clk, reset : clock, asynchronous active-high reset
//   clear      : discard any work in progress and zero the working registers
//   load       : start converting bin (takes WIDTH cycles)
//   bin        : binary magnitude, sampled when load is high
//   done       : high during the final conversion cycle; bcd/ovf update on
//                the edge that ends it
//   bcd        : converted digits, held until the next conversion finishes
//   ovf        : a 1 was shifted out of the top digit (value >= 10^DIGITS)
module bcd_double_dabble
  import mult_bcd_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                load,
  input  logic [WIDTH-1:0]    bin,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic                ovf
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0]    shreg;
  logic [4*DIGITS-1:0] digits;
  logic [4*DIGITS-1:0] corrected;
  logic [4*DIGITS-1:0] digits_next;
  logic                ovf_work;
  logic                ovf_next;
  logic                busy;
  logic [CW-1:0]       cnt;

  // Correction happens before the shift in the same cycle, so the register
  // only ever sees already-corrected, shifted digits. The bit leaving the top
  // digit is dropped from the chain but remembered as a sticky overflow.
  always_comb begin
    corrected = digits;
    for (int i = 0; i < DIGITS; i++) begin
      if (digits[4*i +: 4] >= BCD_CORRECT_THRESH) begin
        corrected[4*i +: 4] = digits[4*i +: 4] + ADD_THREE;
      end
    end
    digits_next = {corrected[4*DIGITS-2:0], shreg[WIDTH-1]};
    ovf_next    = ovf_work | corrected[4*DIGITS-1];
  end

  assign done = busy && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg    <= '0;
      digits   <= '0;
      ovf_work <= 1'b0;
      busy     <= 1'b0;
      cnt      <= '0;
      bcd      <= '0;
      ovf      <= 1'b0;
    end else if (clear) begin
      shreg    <= '0;
      digits   <= '0;
      ovf_work <= 1'b0;
      busy     <= 1'b0;
      cnt      <= '0;
    end else if (load) begin
      shreg    <= bin;
      digits   <= '0;
      ovf_work <= 1'b0;
      busy     <= 1'b1;
      cnt      <= '0;
    end else if (busy) begin
      shreg    <= {shreg[WIDTH-2:0], 1'b0};
      digits   <= digits_next;
      ovf_work <= ovf_next;
      cnt      <= cnt + CW'(1);
      if (done) begin
        busy <= 1'b0;
        bcd  <= digits_next;
        ovf  <= ovf_next;
      end
    end
  end

endmodule

// File: rtl/seq_mult_bcd_conv.sv
// seq_mult_bcd_conv: sequential N-bit shift-add multiplier followed by a
// Double Dabble BCD conversion of the product magnitude, with valid/ready
// handshakes on both sides. One operation in flight; 3N cycles from the
// accepting edge to out_valid.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : slave side of seq_mult_bcd_conv_if (operands in, result out)
// Parameters: N operand width, DIGITS BCD digits, SIGNED two's-complement mode.
module seq_mult_bcd_conv
  import mult_bcd_pkg::*;
#(
  parameter int N      = 8,
  parameter int DIGITS = 5,
  parameter bit SIGNED = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  seq_mult_bcd_conv_if.slave bus
);
  localparam int W  = 2 * N;
  localparam int CW = $clog2(N) + 1;

  state_t              state;
  state_t              state_next;
  logic [W-1:0]        mcand;
  logic [W-1:0]        acc;
  logic [W-1:0]        acc_next;
  logic [N-1:0]        mplr;
  logic [CW-1:0]       count;
  logic                sign_cap;
  logic [W-1:0]        product_q;
  logic                sign_q;
  logic [N-1:0]        a_mag;
  logic [N-1:0]        b_mag;
  logic                accept;
  logic                conv_clear;
  logic                conv_load;
  logic                conv_done;
  logic                mult_last;
  logic                result_neg;
  logic [4*DIGITS-1:0] conv_bcd;
  logic                conv_ovf;

  // |-2^(N-1)| still fits in N unsigned bits, so the magnitudes need no
  // extra width.
  always_comb begin
    a_mag = bus.A;
    b_mag = bus.B;
    if (SIGNED && bus.A[N-1]) a_mag = ~bus.A + N'(1);
    if (SIGNED && bus.B[N-1]) b_mag = ~bus.B + N'(1);
  end

  assign acc_next   = acc + (mplr[0] ? mcand : '0);
  assign mult_last  = (count == CW'(N - 1));
  assign result_neg = sign_cap && (acc != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    conv_clear = 1'b0;
    conv_load  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          accept     = 1'b1;
          conv_clear = 1'b1;
          state_next = MULT;
        end
      end
      MULT: begin
        if (mult_last) begin
          conv_load  = 1'b1;
          state_next = CONV;
        end
      end
      CONV: begin
        if (conv_done) state_next = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The accumulator stays frozen through CONV so the final product and sign
  // can be formed from it on the edge the conversion completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand     <= '0;
      mplr      <= '0;
      acc       <= '0;
      count     <= '0;
      sign_cap  <= 1'b0;
      product_q <= '0;
      sign_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            mcand    <= W'(a_mag);
            mplr     <= b_mag;
            acc      <= '0;
            count    <= '0;
            sign_cap <= SIGNED && (bus.A[N-1] ^ bus.B[N-1]);
          end
        end
        MULT: begin
          acc   <= acc_next;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          count <= count + CW'(1);
        end
        CONV: begin
          if (conv_done) begin
            product_q <= result_neg ? (~acc + W'(1)) : acc;
            sign_q    <= result_neg;
          end
        end
        default: ;
      endcase
    end
  end

  bcd_double_dabble #(
    .WIDTH (W),
    .DIGITS(DIGITS)
  ) u_dd (
    .clk  (clk),
    .reset(reset),
    .clear(conv_clear),
    .load (conv_load),
    .bin  (acc_next),
    .done (conv_done),
    .bcd  (conv_bcd),
    .ovf  (conv_ovf)
  );

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.product   = product_q;
  assign bus.bcd       = conv_bcd;
  assign bus.sign      = sign_q;
  assign bus.bcd_ovf   = conv_ovf;

endmodule

// File: tb/tb_seq_mult_bcd_conv.sv
// tb_seq_mult_bcd_conv: self-checking bench for seq_mult_bcd_conv.
// Three instances share one operand driver and one observation mux:
//   cfg 0 : N=8, DIGITS=5, unsigned
//   cfg 1 : N=8, DIGITS=5, signed
//   cfg 2 : N=8, DIGITS=4, unsigned (decimal overflow cases)
// A table of hand-computed vectors is run first, followed by backpressure and
// mid-conversion reset sequences.
module tb_seq_mult_bcd_conv;
  import mult_bcd_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int         sel = 0;
  logic [7:0] a_drv = '0;
  logic [7:0] b_drv = '0;
  logic       vld_drv = 1'b0;
  logic       rdy_drv = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  seq_mult_bcd_conv_if #(.N(8), .DIGITS(5)) bus0 ();
  seq_mult_bcd_conv_if #(.N(8), .DIGITS(5)) bus1 ();
  seq_mult_bcd_conv_if #(.N(8), .DIGITS(4)) bus2 ();

  seq_mult_bcd_conv #(.N(8), .DIGITS(5), .SIGNED(1'b0)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
  seq_mult_bcd_conv #(.N(8), .DIGITS(5), .SIGNED(1'b1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
  seq_mult_bcd_conv #(.N(8), .DIGITS(4), .SIGNED(1'b0)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2));

  assign bus0.A = a_drv;
  assign bus0.B = b_drv;
  assign bus1.A = a_drv;
  assign bus1.B = b_drv;
  assign bus2.A = a_drv;
  assign bus2.B = b_drv;
  assign bus0.in_valid  = vld_drv && (sel == 0);
  assign bus1.in_valid  = vld_drv && (sel == 1);
  assign bus2.in_valid  = vld_drv && (sel == 2);
  assign bus0.out_ready = rdy_drv && (sel == 0);
  assign bus1.out_ready = rdy_drv && (sel == 1);
  assign bus2.out_ready = rdy_drv && (sel == 2);

  logic        obs_in_ready;
  logic        obs_out_valid;
  logic [15:0] obs_product;
  logic [19:0] obs_bcd;
  logic        obs_sign;
  logic        obs_ovf;

  // Route the selected instance's outputs to one set of observation signals.
  always_comb begin
    obs_in_ready  = bus0.in_ready;
    obs_out_valid = bus0.out_valid;
    obs_product   = bus0.product;
    obs_bcd       = bus0.bcd;
    obs_sign      = bus0.sign;
    obs_ovf       = bus0.bcd_ovf;
    if (sel == 1) begin
      obs_in_ready  = bus1.in_ready;
      obs_out_valid = bus1.out_valid;
      obs_product   = bus1.product;
      obs_bcd       = bus1.bcd;
      obs_sign      = bus1.sign;
      obs_ovf       = bus1.bcd_ovf;
    end else if (sel == 2) begin
      obs_in_ready  = bus2.in_ready;
      obs_out_valid = bus2.out_valid;
      obs_product   = bus2.product;
      obs_bcd       = {4'h0, bus2.bcd};
      obs_sign      = bus2.sign;
      obs_ovf       = bus2.bcd_ovf;
    end
  end

  typedef struct {
    int          cfg;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
    logic [19:0] bcd;
    logic        s;
    logic        ovf;
  } vec_t;

  vec_t        vecs [15];
  logic [15:0] prev_p [3];
  logic [19:0] prev_b [3];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Present operands for one accepting edge, scramble them afterwards, and
  // count cycles until out_valid. lat stays -1 if the result never arrives.
  task automatic applyStimulus(input int cfg, input logic [7:0] a, input logic [7:0] b,
                               input string tag, output int lat);
    @(negedge clk);
    sel     = cfg;
    a_drv   = a;
    b_drv   = b;
    vld_drv = 1'b1;
    #1;
    checkOutput({tag, " in_ready before accept"}, 32'(obs_in_ready), 32'd1);
    @(posedge clk);
    #1;
    vld_drv = 1'b0;
    a_drv   = ~a;
    b_drv   = a ^ 8'h5A;
    lat     = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk);
      #1;
      if (c == 10) begin
        checkOutput({tag, " product held mid-op"}, 32'(obs_product), 32'(prev_p[cfg]));
        checkOutput({tag, " bcd held mid-op"}, 32'(obs_bcd), 32'(prev_b[cfg]));
      end
      if (obs_out_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic finishHandshake(input string tag);
    @(negedge clk);
    rdy_drv = 1'b1;
    @(posedge clk);
    #1;
    rdy_drv = 1'b0;
    checkOutput({tag, " out_valid after accept"}, 32'(obs_out_valid), 32'd0);
    checkOutput({tag, " in_ready after accept"}, 32'(obs_in_ready), 32'd1);
  endtask

  task automatic runVector(input vec_t v, input string tag);
    int lat;
    applyStimulus(v.cfg, v.a, v.b, tag, lat);
    checkOutput({tag, " latency"}, 32'(lat), 32'd24);
    checkOutput({tag, " product"}, 32'(obs_product), 32'(v.p));
    checkOutput({tag, " bcd"}, 32'(obs_bcd), 32'(v.bcd));
    checkOutput({tag, " sign"}, 32'(obs_sign), 32'(v.s));
    checkOutput({tag, " bcd_ovf"}, 32'(obs_ovf), 32'(v.ovf));
    finishHandshake(tag);
    checkOutput({tag, " product kept"}, 32'(obs_product), 32'(v.p));
    prev_p[v.cfg] = v.p;
    prev_b[v.cfg] = v.bcd;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int seen;
    vec_t v;

    vecs[0]  = '{0, 8'd255, 8'd255, 16'hFE01, 20'h65025, 1'b0, 1'b0};
    vecs[1]  = '{0, 8'd0,   8'd0,   16'h0000, 20'h00000, 1'b0, 1'b0};
    vecs[2]  = '{0, 8'd7,   8'd6,   16'h002A, 20'h00042, 1'b0, 1'b0};
    vecs[3]  = '{0, 8'd123, 8'd45,  16'h159F, 20'h05535, 1'b0, 1'b0};
    vecs[4]  = '{0, 8'd100, 8'd100, 16'h2710, 20'h10000, 1'b0, 1'b0};
    vecs[5]  = '{1, 8'hF4,  8'h0B,  16'hFF7C, 20'h00132, 1'b1, 1'b0};
    vecs[6]  = '{1, 8'h80,  8'h80,  16'h4000, 20'h16384, 1'b0, 1'b0};
    vecs[7]  = '{1, 8'hFB,  8'h00,  16'h0000, 20'h00000, 1'b0, 1'b0};
    vecs[8]  = '{1, 8'h7F,  8'h80,  16'hC080, 20'h16256, 1'b1, 1'b0};
    vecs[9]  = '{1, 8'hFF,  8'hFF,  16'h0001, 20'h00001, 1'b0, 1'b0};
    vecs[10] = '{1, 8'h05,  8'hFD,  16'hFFF1, 20'h00015, 1'b1, 1'b0};
    vecs[11] = '{2, 8'd200, 8'd100, 16'h4E20, 20'h00000, 1'b0, 1'b1};
    vecs[12] = '{2, 8'd99,  8'd101, 16'h270F, 20'h09999, 1'b0, 1'b0};
    vecs[13] = '{2, 8'd255, 8'd255, 16'hFE01, 20'h05025, 1'b0, 1'b1};
    vecs[14] = '{2, 8'd100, 8'd100, 16'h2710, 20'h00000, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      prev_p[k] = '0;
      prev_b[k] = '0;
    end

    $display("[TB] N=8 needs %0d digits for a full-range product", min_digits(8));

    // Reset values while reset is held.
    #3;
    for (int k = 0; k < 2; k++) begin
      sel = k;
      #1;
      checkOutput($sformatf("reset cfg%0d in_ready", k), 32'(obs_in_ready), 32'd1);
      checkOutput($sformatf("reset cfg%0d out_valid", k), 32'(obs_out_valid), 32'd0);
      checkOutput($sformatf("reset cfg%0d product", k), 32'(obs_product), 32'd0);
      checkOutput($sformatf("reset cfg%0d bcd", k), 32'(obs_bcd), 32'd0);
      checkOutput($sformatf("reset cfg%0d sign/ovf", k), 32'({obs_sign, obs_ovf}), 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      runVector(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: result held while out_ready stays low, in_valid ignored.
    applyStimulus(0, 8'd12, 8'd34, "bp", lat);
    checkOutput("bp latency", 32'(lat), 32'd24);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vld_drv = c[0];
      a_drv   = 8'd9;
      b_drv   = 8'd9;
      @(posedge clk);
      #1;
      checkOutput($sformatf("bp hold%0d out_valid", c), 32'(obs_out_valid), 32'd1);
      checkOutput($sformatf("bp hold%0d in_ready", c), 32'(obs_in_ready), 32'd0);
      checkOutput($sformatf("bp hold%0d product", c), 32'(obs_product), 32'h0198);
      checkOutput($sformatf("bp hold%0d bcd", c), 32'(obs_bcd), 32'h00408);
    end
    @(negedge clk);
    vld_drv = 1'b0;
    finishHandshake("bp");
    checkOutput("bp product kept", 32'(obs_product), 32'h0198);
    prev_p[0] = 16'h0198;
    prev_b[0] = 20'h00408;

    // Asynchronous reset in the middle of conversion.
    @(negedge clk);
    sel     = 0;
    a_drv   = 8'd200;
    b_drv   = 8'd3;
    vld_drv = 1'b1;
    @(posedge clk);
    #1;
    vld_drv = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midreset in_ready", 32'(obs_in_ready), 32'd1);
    checkOutput("midreset out_valid", 32'(obs_out_valid), 32'd0);
    checkOutput("midreset product", 32'(obs_product), 32'd0);
    checkOutput("midreset bcd", 32'(obs_bcd), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      prev_p[k] = '0;
      prev_b[k] = '0;
    end
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (obs_out_valid) seen++;
    end
    checkOutput("midreset no result", 32'(seen), 32'd0);
    v = '{0, 8'd7, 8'd6, 16'h002A, 20'h00042, 1'b0, 1'b0};
    runVector(v, "after reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
